// File: rtl/simple_vector_multiply_pkg.sv
// Shared FP32 field definitions, operand/product stage records and the
// operand classifier used by the outer-product multiplier.
package simple_vector_multiply_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int LATENCY   = 3;
  localparam int NUM_LANES = 2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_QNAN,
    SP_INF,
    SP_ZERO
  } spec_e;

  // Classified operand: mantissa carries the hidden bit
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
    logic             zero;
    logic             inf;
    logic             nan;
  } op_t;

  // Raw product before normalization; exp is a 10-bit two's-complement sum
  typedef struct packed {
    logic                 sign;
    logic [EXP_W+1:0]     exp;
    logic [2*MAN_W+1:0]   prod;
    spec_e                spec;
  } prod_t;

  // Exponent 0 covers both true zero and subnormals (denormals-are-zero)
  function automatic op_t unpack(input fp32_t f);
    op_t o;
    o.sign = f.sign;
    o.exp  = f.exp;
    o.man  = {1'b1, f.man};
    o.zero = (f.exp == '0);
    o.inf  = (f.exp == '1) && (f.man == '0);
    o.nan  = (f.exp == '1) && (f.man != '0);
    return o;
  endfunction

endpackage

// File: rtl/simple_vector_multiply_if.sv
// Operand/result bundle for the 2x2 FP32 outer-product block.
interface simple_vector_multiply_if;
  logic [31:0] A1, A2, B1, B2;
  logic [31:0] Result11, Result12, Result21, Result22;

  modport master (
    output A1, A2, B1, B2,
    input  Result11, Result12, Result21, Result22
  );

  modport slave (
    input  A1, A2, B1, B2,
    output Result11, Result12, Result21, Result22
  );
endinterface

// File: rtl/simple_vector_multiply_fp32_mul.sv
// Three-stage FP32 multiplier: classify, multiply, normalize/round/pack.
// DAZ on inputs, flush-to-zero on outputs, RNE rounding.
module fp32_mul
  import simple_vector_multiply_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  op_t   s1a_q, s1b_q;
  prod_t s2_d, s2_q;
  logic [31:0] y_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1a_q <= '0;
      s1b_q <= '0;
    end else begin
      s1a_q <= unpack(fp32_t'(a));
      s1b_q <= unpack(fp32_t'(b));
    end
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1a_q.sign ^ s1b_q.sign;
    s2_d.exp  = {2'b00, s1a_q.exp} + {2'b00, s1b_q.exp} - 10'(BIAS);
    s2_d.prod = {24'd0, s1a_q.man} * {24'd0, s1b_q.man};
    if (s1a_q.nan || s1b_q.nan)
      s2_d.spec = SP_QNAN;
    else if ((s1a_q.inf && s1b_q.zero) || (s1a_q.zero && s1b_q.inf))
      s2_d.spec = SP_QNAN;
    else if (s1a_q.inf || s1b_q.inf)
      s2_d.spec = SP_INF;
    else if (s1a_q.zero || s1b_q.zero)
      s2_d.spec = SP_ZERO;
    else
      s2_d.spec = SP_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s2_q <= '0;
    else     s2_q <= s2_d;
  end

  logic [23:0]       m24;
  logic              g, r, st, rup;
  logic [24:0]       m25;
  logic signed [9:0] e;
  logic [22:0]       man_o;

  // Product of two [1,2) mantissas lies in [1,4): bit 47 picks the window
  always_comb begin
    if (s2_q.prod[47]) begin
      m24 = s2_q.prod[47:24];
      g   = s2_q.prod[23];
      r   = s2_q.prod[22];
      st  = |s2_q.prod[21:0];
    end else begin
      m24 = s2_q.prod[46:23];
      g   = s2_q.prod[22];
      r   = s2_q.prod[21];
      st  = |s2_q.prod[20:0];
    end
    rup   = g & (r | st | m24[0]);
    m25   = {1'b0, m24} + 25'(rup);
    man_o = m25[24] ? m25[23:1] : m25[22:0];
    e     = $signed(s2_q.exp) + $signed({9'd0, s2_q.prod[47]})
          + $signed({9'd0, m25[24]});

    case (s2_q.spec)
      SP_QNAN: y_d = QNAN;
      SP_INF:  y_d = {s2_q.sign, 8'hFF, 23'd0};
      SP_ZERO: y_d = {s2_q.sign, 31'd0};
      default: begin
        if (e >= 10'sd255)
          y_d = {s2_q.sign, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
          y_d = {s2_q.sign, 31'd0};
        else
          y_d = {s2_q.sign, e[7:0], man_o};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y <= '0;
    else     y <= y_d;
  end

endmodule

// File: rtl/simple_vector_multiply.sv
// 2x2 FP32 outer product: Result_ij = Ai * Bj, one vector pair per clock,
// built from a lane grid of identical pipelined multipliers.
module simple_vector_multiply
  import simple_vector_multiply_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  simple_vector_multiply_if.slave  bus
);

  logic [NUM_LANES-1:0][31:0]                 a_v, b_v;
  logic [NUM_LANES-1:0][NUM_LANES-1:0][31:0]  r_v;

  assign a_v = {bus.A2, bus.A1};
  assign b_v = {bus.B2, bus.B1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_row
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_col
      fp32_mul u_mul (
        .clk (clk),
        .rst (rst),
        .a   (a_v[i]),
        .b   (b_v[j]),
        .y   (r_v[i][j])
      );
    end
  end

  assign bus.Result11 = r_v[0][0];
  assign bus.Result12 = r_v[0][1];
  assign bus.Result21 = r_v[1][0];
  assign bus.Result22 = r_v[1][1];

endmodule

// File: tb/tb_simple_vector_multiply.sv
// Scoreboard bench for the FP32 outer-product block: expected results are
// queued with their due cycle when driven and popped when they emerge.
module tb_simple_vector_multiply;
  import simple_vector_multiply_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simple_vector_multiply_if bus();

  simple_vector_multiply dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0]       a1, a2, b1, b2;
    logic [3:0][31:0]  r;      // {R22, R21, R12, R11}
    string             name;
  } vec_t;

  typedef struct {
    int                due;
    logic [3:0][31:0]  r;
    string             name;
  } exp_t;

  vec_t  tbl [7];
  exp_t  sb [$];
  string lname [4] = '{"R11", "R12", "R21", "R22"};
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0][31:0] outs();
    return {bus.Result22, bus.Result21, bus.Result12, bus.Result11};
  endfunction

  task automatic drive(input logic [31:0] a1, a2, b1, b2);
    bus.A1 = a1; bus.A2 = a2; bus.B1 = b1; bus.B2 = b2;
  endtask

  task automatic test_reset();
    logic [3:0][31:0] got;
    rst = 1'b1;
    drive(32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000);
    #1;
    got = outs();
    for (int q = 0; q < 4; q++) begin
      n_chk++;
      if (got[q] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_async %s: got %h expected %h", lname[q], got[q], 32'h0);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = outs();
    for (int q = 0; q < 4; q++) begin
      n_chk++;
      if (got[q] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_held %s: got %h expected %h", lname[q], got[q], 32'h0);
      end
    end
    rst = 1'b0;
    drive('0, '0, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      got = outs();
      for (int q = 0; q < 4; q++) begin
        n_chk++;
        if (got[q] !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_zero_in %s: got %h expected %h", lname[q], got[q], 32'h0);
        end
      end
    end
  endtask

  // Streams the whole table back to back, one vector pair per clock
  task automatic test_back_to_back();
    logic [3:0][31:0] got;
    exp_t e;
    for (int t = 0; t < 7 + LATENCY + 2; t++) begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        got = outs();
        for (int q = 0; q < 4; q++) begin
          n_chk++;
          if (got[q] !== e.r[q]) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", e.name, lname[q], got[q], e.r[q]);
          end
        end
      end
      if (t < 7) begin
        drive(tbl[t].a1, tbl[t].a2, tbl[t].b1, tbl[t].b2);
        sb.push_back('{due: cyc + LATENCY, r: tbl[t].r, name: tbl[t].name});
      end else begin
        drive('0, '0, '0, '0);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: got no result expected %h", e.name, e.r);
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0][31:0] got;
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive(tbl[t].a1, tbl[t].a2, tbl[t].b1, tbl[t].b2);
      sb.push_back('{due: cyc + LATENCY, r: tbl[t].r, name: "mid_pre"});
    end
    @(negedge clk);
    drive('0, '0, '0, '0);
    e = sb.pop_front();
    got = outs();
    n_chk++;
    if (e.due != cyc || got !== e.r) begin
      n_fail++;
      $display("FAIL mid_pre: got %h expected %h", got, e.r);
    end
    rst = 1'b1;
    sb.delete();
    #1;
    got = outs();
    for (int q = 0; q < 4; q++) begin
      n_chk++;
      if (got[q] !== 32'h0) begin
        n_fail++;
        $display("FAIL mid_reset_async %s: got %h expected %h", lname[q], got[q], 32'h0);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = outs();
      for (int q = 0; q < 4; q++) begin
        n_chk++;
        if (got[q] !== 32'h0) begin
          n_fail++;
          $display("FAIL mid_no_stale %s: got %h expected %h", lname[q], got[q], 32'h0);
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000,
               {32'h41C00000, 32'h41A00000, 32'h41900000, 32'h41700000}, "outer"};
    tbl[1] = '{32'h40C00000, 32'h40A00000, 32'h40800000, 32'h40400000,
               {32'h41700000, 32'h41A00000, 32'h41900000, 32'h41C00000}, "outer_b2b"};
    tbl[2] = '{32'h00000003, 32'h00000004, 32'h00000005, 32'h00000006,
               {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}, "subnormal"};
    tbl[3] = '{32'h7F7FFFFF, 32'h7F800000, 32'h40000000, 32'h00000000,
               {32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7F800000}, "ovf_inf"};
    tbl[4] = '{32'hBF800000, 32'h7FC00000, 32'h40000000, 32'h3F800000,
               {32'h7FC00000, 32'h7FC00000, 32'hBF800000, 32'hC0000000}, "sign_nan"};
    tbl[5] = '{32'h3F800001, 32'h3F800000, 32'h3F800001, 32'h3FC00000,
               {32'h3FC00000, 32'h3F800001, 32'h3FC00002, 32'h3F800002}, "round"};
    tbl[6] = '{32'h00800000, 32'h80800000, 32'h3F000000, 32'h3F800000,
               {32'h80800000, 32'h80000000, 32'h00800000, 32'h00000000}, "underflow"};

    test_reset();
    test_back_to_back();
    test_reset_midstream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
